// File: rtl/audio_pkg.sv
// Shared constants for the audio playback path.
//   State codes for the playback scheduler, sample/counter widths,
//   the silence value and a saturating increment helper.
package audio_pkg;

  localparam int unsigned SAMPLE_W   = 16;
  localparam int unsigned UNDERRUN_W = 8;
  localparam int unsigned STATE_W    = 2;

  localparam logic [STATE_W-1:0] ST_IDLE    = 2'd0;
  localparam logic [STATE_W-1:0] ST_PREFILL = 2'd1;
  localparam logic [STATE_W-1:0] ST_PLAY    = 2'd2;

  localparam logic [SAMPLE_W-1:0] SILENCE = 16'h0000;

  // Increment that sticks at all-ones instead of wrapping.
  function automatic logic [UNDERRUN_W-1:0] sat_inc(input logic [UNDERRUN_W-1:0] v);
    return (v == '1) ? v : v + UNDERRUN_W'(1);
  endfunction

endpackage

// File: rtl/sample_fifo.sv
// Single-clock sample FIFO with registered read data.
//   clk, rst_n   : clock, asynchronous active-low reset
//   flush        : empties the FIFO and zeroes rd_data (wins over push/pop)
//   push/wr_data : write request; dropped when full unless a pop coincides
//   pop          : read request; rd_data is valid the cycle after. Popping an
//                  empty FIFO loads EMPTY_DATA into rd_data and moves nothing.
//   rd_data      : registered read data, held until the next pop/flush
//   full, empty  : registered, derived from the occupancy counter
//   level        : registered occupancy
module sample_fifo #(
  parameter int unsigned     DEPTH      = 16,
  parameter int unsigned     WIDTH      = 16,
  parameter logic [WIDTH-1:0] EMPTY_DATA = '0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     flush,
  input  logic                     push,
  input  logic [WIDTH-1:0]         wr_data,
  input  logic                     pop,
  output logic [WIDTH-1:0]         rd_data,
  output logic                     full,
  output logic                     empty,
  output logic [$clog2(DEPTH):0]   level
);

  localparam int unsigned PTR_W   = $clog2(DEPTH);
  localparam int unsigned LEVEL_W = PTR_W + 1;

  logic [WIDTH-1:0]   mem [DEPTH];
  logic [PTR_W-1:0]   wr_ptr, rd_ptr;
  logic               do_push, do_pop;
  logic [LEVEL_W-1:0] level_next;

  // A full FIFO still accepts a push when a pop frees a slot in the same cycle.
  always_comb begin
    do_pop     = pop && !empty;
    do_push    = push && (!full || do_pop);
    level_next = level;
    if (flush) begin
      level_next = '0;
    end else if (do_push && !do_pop) begin
      level_next = level + LEVEL_W'(1);
    end else if (!do_push && do_pop) begin
      level_next = level - LEVEL_W'(1);
    end
  end

  // Storage array, no reset needed.
  always_ff @(posedge clk) begin
    if (do_push && !flush) begin
      mem[wr_ptr] <= wr_data;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      rd_data <= EMPTY_DATA;
      level   <= '0;
      full    <= 1'b0;
      empty   <= 1'b1;
    end else begin
      level <= level_next;
      full  <= (level_next == LEVEL_W'(DEPTH));
      empty <= (level_next == '0);
      if (flush) begin
        wr_ptr  <= '0;
        rd_ptr  <= '0;
        rd_data <= EMPTY_DATA;
      end else begin
        if (do_push) begin
          wr_ptr <= wr_ptr + PTR_W'(1);
        end
        if (pop) begin
          rd_data <= empty ? EMPTY_DATA : mem[rd_ptr];
        end
        if (do_pop) begin
          rd_ptr <= rd_ptr + PTR_W'(1);
        end
      end
    end
  end

endmodule

// File: rtl/audio_playback_scheduler.sv
// Audio playback scheduler: buffers incoming samples, prefills, then releases
// one sample every CLK_DIV clocks to the output stage.
//   clk_25mhz, reset_n : clock, asynchronous active-low reset
//   enable             : playback enable (level)
//   s_valid, s_data    : incoming sample pulse and data
//   clear_flags        : pulse, clears overrun_flag and underrun_count
//   sample_out         : current output sample, held between strobes
//   sample_strobe      : one-cycle pulse when sample_out updates
//   playing            : high while in PLAY
//   overrun_flag       : sticky, a sample was dropped on a full FIFO
//   underrun_count     : saturating count of underruns
//   fill_level         : FIFO occupancy
module audio_playback_scheduler
  import audio_pkg::*;
#(
  parameter int unsigned CLK_DIV    = 1133,
  parameter int unsigned FIFO_DEPTH = 16,
  parameter int unsigned PREFILL    = 8
) (
  input  logic                        clk_25mhz,
  input  logic                        reset_n,
  input  logic                        enable,
  input  logic                        s_valid,
  input  logic [SAMPLE_W-1:0]         s_data,
  input  logic                        clear_flags,
  output logic [SAMPLE_W-1:0]         sample_out,
  output logic                        sample_strobe,
  output logic                        playing,
  output logic                        overrun_flag,
  output logic [UNDERRUN_W-1:0]       underrun_count,
  output logic [$clog2(FIFO_DEPTH):0] fill_level
);

  localparam int unsigned TICK_W  = $clog2(CLK_DIV);
  localparam int unsigned LEVEL_W = $clog2(FIFO_DEPTH) + 1;

  localparam logic [TICK_W-1:0]  TICK_LAST     = TICK_W'(CLK_DIV - 1);
  localparam logic [LEVEL_W-1:0] PREFILL_LEVEL = LEVEL_W'(PREFILL);

  logic [STATE_W-1:0] state, state_next;
  logic [TICK_W-1:0]  tick, tick_next;
  logic               fifo_push, fifo_pop, fifo_flush;
  logic               fifo_full, fifo_empty;
  logic               tick_end, underrun, overrun;

  // Sample buffer; a pop on empty yields silence, which covers the underrun output.
  sample_fifo #(
    .DEPTH      (FIFO_DEPTH),
    .WIDTH      (SAMPLE_W),
    .EMPTY_DATA (SILENCE)
  ) u_fifo (
    .clk     (clk_25mhz),
    .rst_n   (reset_n),
    .flush   (fifo_flush),
    .push    (fifo_push),
    .wr_data (s_data),
    .pop     (fifo_pop),
    .rd_data (sample_out),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .level   (fill_level)
  );

  // Next-state, tick divider and FIFO controls.
  always_comb begin
    state_next = state;
    tick_next  = '0;
    fifo_flush = 1'b0;
    fifo_push  = 1'b0;
    fifo_pop   = 1'b0;
    tick_end   = 1'b0;
    if (!enable) begin
      state_next = ST_IDLE;
      fifo_flush = 1'b1;
    end else begin
      case (state)
        ST_IDLE: begin
          state_next = ST_PREFILL;
          fifo_flush = 1'b1;
        end
        ST_PREFILL: begin
          fifo_push = s_valid;
          if (fill_level >= PREFILL_LEVEL) begin
            state_next = ST_PLAY;
          end
        end
        ST_PLAY: begin
          fifo_push = s_valid;
          tick_next = tick + TICK_W'(1);
          if (tick == TICK_LAST) begin
            tick_end  = 1'b1;
            tick_next = '0;
            fifo_pop  = 1'b1;
            if (fifo_empty) begin
              state_next = ST_PREFILL;
            end
          end
        end
        default: begin
          state_next = ST_IDLE;
        end
      endcase
    end
  end

  assign underrun = tick_end && fifo_empty;
  // A full FIFO with a coincident pop accepts the push, so it is not an overrun.
  assign overrun  = fifo_push && fifo_full && !fifo_pop;

  // State and tick registers.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      state <= ST_IDLE;
      tick  <= '0;
    end else begin
      state <= state_next;
      tick  <= tick_next;
    end
  end

  // Strobe, playing and sticky status; a same-cycle event beats clear_flags.
  always_ff @(posedge clk_25mhz or negedge reset_n) begin
    if (!reset_n) begin
      sample_strobe  <= 1'b0;
      playing        <= 1'b0;
      overrun_flag   <= 1'b0;
      underrun_count <= '0;
    end else begin
      sample_strobe <= tick_end;
      playing       <= (state_next == ST_PLAY);
      if (overrun) begin
        overrun_flag <= 1'b1;
      end else if (clear_flags) begin
        overrun_flag <= 1'b0;
      end
      if (underrun) begin
        underrun_count <= clear_flags ? UNDERRUN_W'(1) : sat_inc(underrun_count);
      end else if (clear_flags) begin
        underrun_count <= '0;
      end
    end
  end

endmodule
